// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared definitions for the AXI4-Lite register memory slave.
// Holds default bus widths, response encodings and the FSM state types.
// Build option AXI4_LITE_WSTRB_EN (used by axi4_lite_slave_mem) enables byte strobes.
package axi4_lite_Defs;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by Mem_Depth word registers; independent read and write FSMs.
// Latency: BVALID one cycle after both AW and W are held; RVALID one cycle after AR handshake.
// Backpressure: B/R outputs hold stable until BREADY/RREADY; no new AW/W/AR accepted meanwhile.
// Build option: define AXI4_LITE_WSTRB_EN to honour WSTRB; otherwise full words are written.
module axi4_lite_slave_mem
  import axi4_lite_Defs::*;
#(
  parameter int Addr_Width = ADDR_WIDTH,
  parameter int Data_Width = DATA_WIDTH,
  parameter int Mem_Depth  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [Addr_Width-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [Data_Width-1:0]   WDATA,
  input  logic [Data_Width/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [Addr_Width-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [Data_Width-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int IdxW  = (Mem_Depth > 1) ? $clog2(Mem_Depth) : 1;
  localparam int StrbW = Data_Width / 8;
  localparam logic [Addr_Width-1:0] AddrLimit = Addr_Width'(4 * Mem_Depth);

  logic [Data_Width-1:0] mem_q [Mem_Depth];

  // Write channel state
  wr_state_e             wstate_q, wstate_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [Addr_Width-1:0] awaddr_q, awaddr_d;
  logic [Data_Width-1:0] wdata_q, wdata_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
`ifdef AXI4_LITE_WSTRB_EN
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
`else
  logic                  unused_wstrb;
  assign unused_wstrb = ^WSTRB;
`endif

  // Read channel state
  rd_state_e             rstate_q, rstate_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [Data_Width-1:0] rdata_q, rdata_d;

  // Address decode: misaligned or beyond the array is an error.
  logic            aw_err, ar_err;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic            wr_en;
  logic [Data_Width-1:0] wr_word;

  assign aw_err = (awaddr_q[1:0] != 2'b00) || (awaddr_q >= AddrLimit);
  assign ar_err = (ARADDR[1:0] != 2'b00) || (ARADDR >= AddrLimit);
  assign wr_idx = awaddr_q[IdxW+1:2];
  assign rd_idx = ARADDR[IdxW+1:2];

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  // Merge captured write data with the current word, keeping bytes whose strobe is low.
  always_comb begin
    wr_word = wdata_q;
`ifdef AXI4_LITE_WSTRB_EN
    for (int b = 0; b < StrbW; b++) begin
      if (!wstrb_q[b]) wr_word[8*b +: 8] = mem_q[wr_idx][8*b +: 8];
    end
`endif
  end

  // Write FSM next state: collect AW and W in any order, commit, then hold B until BREADY.
  always_comb begin
    wstate_d  = wstate_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en     = 1'b0;
`ifdef AXI4_LITE_WSTRB_EN
    wstrb_d   = wstrb_q;
`endif
    case (wstate_q)
      W_IDLE: begin
        if (AWVALID && awready_q) begin
          aw_done_d = 1'b1;
          awaddr_d  = AWADDR;
        end
        if (WVALID && wready_q) begin
          w_done_d = 1'b1;
          wdata_d  = WDATA;
`ifdef AXI4_LITE_WSTRB_EN
          wstrb_d  = WSTRB;
`endif
        end
        if (aw_done_q && w_done_q) begin
          wr_en     = !aw_err;
          wstate_d  = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = aw_err ? RESP_SLVERR : RESP_OKAY;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          wstate_d = W_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE) && !aw_done_d;
    wready_d  = (wstate_d == W_IDLE) && !w_done_d;
  end

  // Write FSM registers; reset discards any half-captured AW/W.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
`ifdef AXI4_LITE_WSTRB_EN
      wstrb_q   <= '0;
`endif
    end else begin
      wstate_q  <= wstate_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
`ifdef AXI4_LITE_WSTRB_EN
      wstrb_q   <= wstrb_d;
`endif
    end
  end

  // Read FSM next state: sample the array at AR handshake, hold R until RREADY.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rresp_d  = ar_err ? RESP_SLVERR : RESP_OKAY;
          rdata_d  = ar_err ? '0 : mem_q[rd_idx];
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // Read FSM registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Register array; a read in the commit cycle sees the old value via non-blocking update.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < Mem_Depth; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed self-checking bench for axi4_lite_slave_mem (default 32-bit, 16 registers).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants per scenario.
module tb_axi4_lite_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int checks = 0;
  int errors = 0;

  axi4_lite_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // Full write transaction; returns BRESP. A missing response counts as a failure.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    logic aw_pend, w_pend, aw_fire, w_fire;
    int n;
    AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1; BREADY = 1'b0;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_fire = aw_pend && AWREADY;
      w_fire  = w_pend && WREADY;
      tick;
      if (aw_fire) begin AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_fire)  begin WVALID = 1'b0;  w_pend = 1'b0;  end
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin tick; n++; end
    if (!BVALID) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h: no BVALID", a);
    end
    resp = BRESP;
    BREADY = 1'b1;
    tick;
    BREADY = 1'b0;
  endtask

  // Full read transaction; returns RDATA and RRESP.
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0; n = 0;
    while (!ARREADY && n < 20) begin tick; n++; end
    tick;
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin tick; n++; end
    if (!RVALID) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h: no RVALID", a);
    end
    d = RDATA; resp = RRESP;
    RREADY = 1'b1;
    tick;
    RREADY = 1'b0;
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0;
    repeat (3) tick;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b want 000", {AWREADY, WREADY, ARREADY});
    end
    checks++;
    if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0) begin
      errors++; $display("FAIL reset_resp: bv=%b rv=%b bresp=%b rresp=%b want all 0",
                         BVALID, RVALID, BRESP, RRESP);
    end
    checks++;
    if (RDATA !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 00000000", RDATA);
    end
    ARESET = 1'b0;
    tick;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++; $display("FAIL post_reset_ready: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_same_cycle;
    AWADDR = 32'h04; AWVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1; BREADY = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    checks++;
    if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
      errors++; $display("FAIL same_cycle_hs: awr/wr/bv=%b want 000", {AWREADY, WREADY, BVALID});
    end
    tick;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++; $display("FAIL same_cycle_b: bv=%b bresp=%b want 1/00", BVALID, BRESP);
    end
    tick;
    BREADY = 0;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      errors++; $display("FAIL same_cycle_bdone: bv=%b awr=%b want 0/1", BVALID, AWREADY);
    end
    ARADDR = 32'h04; ARVALID = 1; RREADY = 0;
    tick;
    ARVALID = 0;
    checks++;
    if (RVALID !== 1'b1 || ARREADY !== 1'b0 || RDATA !== 32'hDEADBEEF || RRESP !== 2'b00) begin
      errors++; $display("FAIL same_cycle_read: rv=%b arr=%b rdata=%h rresp=%b want 1/0/deadbeef/00",
                         RVALID, ARREADY, RDATA, RRESP);
    end
    RREADY = 1;
    tick;
    RREADY = 0;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      errors++; $display("FAIL same_cycle_rdone: rv=%b arr=%b want 0/1", RVALID, ARREADY);
    end
  endtask

  task automatic test_w_before_aw;
    int bv_cnt;
    logic [31:0] d;
    logic [1:0]  r;
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1; BREADY = 1;
    tick;
    WVALID = 0;
    bv_cnt = BVALID ? 1 : 0;
    checks++;
    if (WREADY !== 1'b0 || AWREADY !== 1'b1) begin
      errors++; $display("FAIL w_first_ready: wr=%b awr=%b want 0/1", WREADY, AWREADY);
    end
    repeat (2) begin tick; if (BVALID) bv_cnt++; end
    checks++;
    if (bv_cnt !== 0) begin
      errors++; $display("FAIL w_first_early_b: saw %0d BVALID cycles want 0", bv_cnt);
    end
    AWADDR = 32'h08; AWVALID = 1;
    tick;
    AWVALID = 0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("FAIL w_first_b_hs: bv=%b want 0", BVALID);
    end
    tick;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++; $display("FAIL w_first_b: bv=%b bresp=%b want 1/00", BVALID, BRESP);
    end
    bv_cnt = 0;
    repeat (3) begin tick; if (BVALID) bv_cnt++; end
    BREADY = 0;
    checks++;
    if (bv_cnt !== 0) begin
      errors++; $display("FAIL w_first_single_b: extra BVALID cycles %0d want 0", bv_cnt);
    end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h12345678 || r !== 2'b00) begin
      errors++; $display("FAIL w_first_read: rdata=%h rresp=%b want 12345678/00", d, r);
    end
  endtask

  task automatic test_errors;
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h40, 32'hA5A5A5A5, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin
      errors++; $display("FAIL err_write_range: bresp=%b want 10", r);
    end
    axi_write(32'h02, 32'h5A5A5A5A, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin
      errors++; $display("FAIL err_write_align: bresp=%b want 10", r);
    end
    axi_read(32'h06, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL err_read_align: rdata=%h rresp=%b want 00000000/10", d, r);
    end
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL err_read_range: rdata=%h rresp=%b want 00000000/10", d, r);
    end
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL err_no_alias_write: reg0=%h rresp=%b want 00000000/00", d, r);
    end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL err_reg4_kept: got %h want deadbeef", d);
    end
  endtask

  task automatic test_backpressure;
    AWADDR = 32'h0C; AWVALID = 1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1; BREADY = 0;
    tick;
    AWVALID = 0; WVALID = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        errors++; $display("FAIL bp_write_hold cyc%0d: bv=%b bresp=%b awr=%b wr=%b want 1/00/0/0",
                           i, BVALID, BRESP, AWREADY, WREADY);
      end
      tick;
    end
    BREADY = 1;
    tick;
    BREADY = 0;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      errors++; $display("FAIL bp_write_release: bv=%b awr=%b want 0/1", BVALID, AWREADY);
    end
    ARADDR = 32'h0C; ARVALID = 1; RREADY = 0;
    tick;
    ARVALID = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (RVALID !== 1'b1 || RDATA !== 32'hCAFEF00D || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
        errors++; $display("FAIL bp_read_hold cyc%0d: rv=%b rdata=%h rresp=%b arr=%b want 1/cafef00d/00/0",
                           i, RVALID, RDATA, RRESP, ARREADY);
      end
      tick;
    end
    RREADY = 1;
    tick;
    RREADY = 0;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      errors++; $display("FAIL bp_read_release: rv=%b arr=%b want 0/1", RVALID, ARREADY);
    end
  endtask

  task automatic test_wstrb;
    logic [31:0] d, exp;
    logic [1:0]  r;
`ifdef AXI4_LITE_WSTRB_EN
    exp = 32'hFF00FF00;
`else
    exp = 32'h00000000;
`endif
    axi_write(32'h00, 32'hFFFFFFFF, 4'hF, r);
    axi_write(32'h00, 32'h00000000, 4'b0101, r);
    axi_read(32'h00, d, r);
    checks++;
    if (d !== exp || r !== 2'b00) begin
      errors++; $display("FAIL wstrb_merge: rdata=%h rresp=%b want %h/00", d, r, exp);
    end
  endtask

  task automatic test_read_during_write;
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h10, 32'h11111111, 4'hF, r);
    AWADDR = 32'h10; AWVALID = 1; WDATA = 32'h22222222; WSTRB = 4'hF; WVALID = 1; BREADY = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    ARADDR = 32'h10; ARVALID = 1; RREADY = 0;
    tick;
    ARVALID = 0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h11111111 || BVALID !== 1'b1) begin
      errors++; $display("FAIL rdw_old_value: rv=%b rdata=%h bv=%b want 1/11111111/1",
                         RVALID, RDATA, BVALID);
    end
    RREADY = 1;
    tick;
    RREADY = 0; BREADY = 0;
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'h22222222) begin
      errors++; $display("FAIL rdw_new_value: got %h want 22222222", d);
    end
  endtask

  task automatic test_reset_mid;
    int bv_cnt;
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h14, 32'h00000055, 4'hF, r);
    AWADDR = 32'h1C; AWVALID = 1; WDATA = 32'h00000066; WSTRB = 4'hF; WVALID = 1; BREADY = 0;
    tick;
    AWVALID = 0; WVALID = 0;
    tick;
    checks++;
    if (BVALID !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: bv=%b want 1", BVALID);
    end
    #2 ARESET = 1;
    #1;
    checks++;
    if (BVALID !== 1'b0 || {AWREADY, WREADY, ARREADY} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_async: bv=%b ready=%b want 0/000", BVALID, {AWREADY, WREADY, ARREADY});
    end
    tick;
    ARESET = 0;
    tick;
    WDATA = 32'h00000077; WSTRB = 4'hF; WVALID = 1;
    tick;
    WVALID = 0;
    checks++;
    if (WREADY !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wcap: wr=%b want 0", WREADY);
    end
    ARESET = 1;
    tick;
    ARESET = 0;
    tick;
    checks++;
    if (WREADY !== 1'b1 || AWREADY !== 1'b1) begin
      errors++; $display("FAIL rst_mid_wdiscard: wr=%b awr=%b want 1/1", WREADY, AWREADY);
    end
    AWADDR = 32'h18; AWVALID = 1; BREADY = 1;
    tick;
    AWVALID = 0;
    bv_cnt = 0;
    repeat (3) begin tick; if (BVALID) bv_cnt++; end
    checks++;
    if (bv_cnt !== 0) begin
      errors++; $display("FAIL rst_mid_stale_pair: BVALID cycles %0d want 0", bv_cnt);
    end
    WDATA = 32'h00000099; WVALID = 1;
    tick;
    WVALID = 0;
    tick;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++; $display("FAIL rst_mid_fresh_b: bv=%b bresp=%b want 1/00", BVALID, BRESP);
    end
    tick;
    BREADY = 0;
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'h00000099) begin
      errors++; $display("FAIL rst_mid_fresh_data: got %h want 00000099", d);
    end
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_mid_clear14: got %h want 00000000", d);
    end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_mid_clear04: got %h want 00000000", d);
    end
    axi_read(32'h1C, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_mid_clear1c: got %h want 00000000", d);
    end
  endtask

  initial begin
    test_reset;
    test_same_cycle;
    test_w_before_aw;
    test_errors;
    test_backpressure;
    test_wstrb;
    test_read_during_write;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_mem.md
AXI4_LITE_SLAVE_MEM -- requirements
Module: axi4_lite_slave_mem

Interface
REQ-001 SHALL: Addr_Width, default from package (32), AXI address width.
REQ-002 SHALL: Data_Width, default from package (32), AXI data width.
REQ-003 SHALL: Mem_Depth, default 16, number of Data_Width-bit registers.
REQ-004 SHALL: ACLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL: ARESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL: AWADDR  input  Addr_Width  write address.
REQ-007 SHALL: AWVALID  input  1  write address valid.
REQ-008 SHALL: AWREADY  output  1  write address ready.
REQ-009 SHALL: WDATA  input  Data_Width  write data.
REQ-010 SHALL: WSTRB  input  Data_Width/8  byte strobes.
REQ-011 SHALL: WVALID  input  1  write data valid.
REQ-012 SHALL: WREADY  output  1  write data ready.
REQ-013 SHALL: BRESP  output  2  write response (00 OKAY, 10 SLVERR).
REQ-014 SHALL: BVALID  output  1  write response valid.
REQ-015 SHALL: BREADY  input  1  write response ready.
REQ-016 SHALL: ARADDR  input  Addr_Width  read address.
REQ-017 SHALL: ARVALID  input  1  read address valid.
REQ-018 SHALL: ARREADY  output  1  read address ready.
REQ-019 SHALL: RDATA  output  Data_Width  read data.
REQ-020 SHALL: RRESP  output  2  read response.
REQ-021 SHALL: RVALID  output  1  read data valid.
REQ-022 SHALL: RREADY  input  1  read data ready.

Function
REQ-023 SHALL: handshake on a channel = VALID & READY high at the same rising edge; outputs registered.
REQ-024 SHALL: write FSM states W_IDLE, W_RESP. In W_IDLE: AWREADY=1 until AW captured; WREADY=1 until W captured. AW and W are accepted in either order or in the same cycle.
REQ-025 SHALL: when both AW and W are captured, the write commits on the next edge, FSM enters W_RESP with BVALID=1. Same-cycle AW+W gives BVALID 1 cycle after the handshake.
REQ-026 SHALL: in W_RESP, AWREADY=WREADY=0; BVALID holds with stable BRESP until BREADY; then to W_IDLE.
REQ-027 SHALL: read FSM states R_IDLE (ARREADY=1), R_DATA (RVALID=1, ARREADY=0). AR handshake gives RVALID next cycle; RDATA/RRESP stable until RREADY; then to R_IDLE.
REQ-028 SHALL: word index = addr[log2(Mem_Depth)+1:2]. addr[1:0]!=0 or addr >= 4*Mem_Depth -> SLVERR, no write, RDATA=0; else OKAY.
REQ-029 SHALL: read and write FSMs are independent. Read sampled at AR handshake while the same-address write commits that edge returns the pre-write value.
REQ-030 SHALL: a read of a register written earlier returns the last committed value.

Reset
REQ-031 SHALL: ARESET asserted (including mid-transaction) forces: both FSMs idle; BVALID=RVALID=0; AWREADY=WREADY=ARREADY=0 while asserted, 1 from the first edge after deassert; BRESP=RRESP=00; RDATA=0; all registers 0; captured AW/W discarded.

Configuration
REQ-032 SHALL: with AXI4_LITE_WSTRB_EN defined, only bytes with WSTRB[i]=1 are written. Without it, WSTRB is ignored and the full word is written.

Structure
REQ-033 SHALL: Addr_Width, Data_Width, response encodings (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and FSM state enums live in package axi4_lite_Defs.
REQ-034 SHALL: no sub-module; single module with two FSMs and the register array.

Verification
REQ-035 SHALL: same-cycle AW=0x04, W=0xDEADBEEF, WSTRB=F, BREADY=1 -> BVALID 1 cycle later, BRESP=00. Then read 0x04 -> RDATA=0xDEADBEEF, RRESP=00.
REQ-036 SHALL: W (0x12345678) 3 cycles before AW=0x08 -> single BVALID after AW capture. Read 0x08 -> 0x12345678.
REQ-037 SHALL: write 0x40 (Mem_Depth=16) and read 0x06 -> BRESP=10, RRESP=10, RDATA=0, no register changes.
REQ-038 SHALL: BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stable; AWREADY/ARREADY stay 0.
REQ-039 SHALL: with AXI4_LITE_WSTRB_EN, reg 0x00=0xFFFFFFFF, write 0x00000000 with WSTRB=0101 -> read 0xFF00FF00. Without it -> 0x00000000.
REQ-040 SHALL: ARESET asserted while BVALID=1 and after a W-only capture -> BVALID=0 immediately, all registers read 0, the next AW does not pair with the stale W.
